// File: rtl/demux_scan_pkg.sv
// demux_scan_pkg: shared types and constants for the demux scan sequencer.
//   scan_state_t : sequencer FSM state (StIdle, StScan)
//   CH_NUM       : number of demux channels
//   SEL_W        : width of the demux select bus
//   DWELL_W      : width of the per-slot dwell counter
//   first_idx()  : channel that opens a scan for a given scan direction
//   last_idx()   : channel that closes a scan for a given scan direction
package demux_scan_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StScan = 1'b1
    } scan_state_t;

    localparam int unsigned CH_NUM  = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DWELL_W = 4;

    function automatic logic [SEL_W-1:0] first_idx(input bit lsb_first);
        return lsb_first ? '0 : SEL_W'(CH_NUM - 1);
    endfunction

    function automatic logic [SEL_W-1:0] last_idx(input bit lsb_first);
        return lsb_first ? SEL_W'(CH_NUM - 1) : '0;
    endfunction

endpackage

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: accepts an 8-bit word over valid/ready and walks the 1-to-8 demux
// select lines through all channels, presenting word[S] on D for each slot.
//
// Parameters:
//   LSB_FIRST : 1 = scan channel 0 -> 7, 0 = scan channel 7 -> 0
//   DWELL     : cycles per slot (1..15), only honoured with DEMUX_SCAN_DWELL_EN
//
// Build option:
//   DEMUX_SCAN_DWELL_EN : when defined, each slot is held for DWELL cycles by a
//                         4-bit dwell counter; otherwise every slot is one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   word to scan, bit i goes to channel i
//   in_valid   in   in_data is offered
//   in_ready   out  word can be accepted this cycle
//   S          out  demux select (current channel)
//   D          out  demux data (word[S] during a slot, else 0)
//   slot_valid out  a slot is being presented
//   busy       out  scan in progress
//   done       out  one-cycle pulse after the final slot of a word
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned DWELL     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH_NUM-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] S,
    output logic             D,
    output logic             slot_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] FirstIdx = first_idx(LSB_FIRST);
    localparam logic [SEL_W-1:0] LastIdx  = last_idx(LSB_FIRST);

    if (DWELL < 1 || DWELL > 15) begin : g_dwell_range
        $error("demux_scan_ctrl: DWELL must be in 1..15");
    end

    scan_state_t       state_q;
    logic [SEL_W-1:0]  idx_q;
    logic [CH_NUM-1:0] word_q;
    logic              done_q;

    logic slot_end;
    logic last_cycle;
    logic accept;

`ifdef DEMUX_SCAN_DWELL_EN
    localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] dwell_q;

    assign slot_end = (dwell_q == DwellLast);

    // Counts cycles within the current slot; cleared on every slot advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
        end else if (state_q == StScan && !slot_end) begin
            dwell_q <= dwell_q + 1'b1;
        end else begin
            dwell_q <= '0;
        end
    end
`else
    assign slot_end = 1'b1;
`endif

    // Final cycle of the terminal slot: a new word can be taken with no idle gap.
    assign last_cycle = (state_q == StScan) && (idx_q == LastIdx) && slot_end;
    assign in_ready   = (state_q == StIdle) || last_cycle;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        word_q  <= in_data;
                        idx_q   <= FirstIdx;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (slot_end) begin
                        if (idx_q == LastIdx) begin
                            done_q <= 1'b1;
                            if (accept) begin
                                word_q <= in_data;
                                idx_q  <= FirstIdx;
                            end else begin
                                idx_q   <= '0;
                                state_q <= StIdle;
                            end
                        end else if (LSB_FIRST) begin
                            idx_q <= idx_q + 3'd1;
                        end else begin
                            idx_q <= idx_q - 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode registered state only.
    assign slot_valid = (state_q == StScan);
    assign busy       = slot_valid;
    assign S          = slot_valid ? idx_q : '0;
    assign D          = slot_valid & word_q[idx_q];
    assign done       = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl: instance a scans LSB first, instance b
// scans MSB first. Expected slots are queued when a word is offered and consumed by
// a per-instance monitor at the falling clock edge.
module tb_demux_scan_ctrl;

`ifdef DEMUX_SCAN_DWELL_EN
    localparam int DW = 3;
`else
    localparam int DW = 1;
`endif

    typedef struct {
        logic [2:0] s;
        logic       d;
        logic       last;
    } slot_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] seq;   // D expected in slot order, bit k = slot k
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_in_data = '0, b_in_data = '0;
    logic       a_in_valid = 1'b0, b_in_valid = 1'b0;
    logic       a_in_ready, b_in_ready;
    logic [2:0] a_S, b_S;
    logic       a_D, b_D, a_slot_valid, b_slot_valid, a_busy, b_busy, a_done, b_done;

    int n_checks = 0;
    int n_fail   = 0;

    slot_t qa[$];
    slot_t qb[$];
    bit    done_exp[2];
    bit    cont[2];
    int    run[2];
    int    run_max[2];

    always #5 clk = ~clk;

    demux_scan_ctrl #(.LSB_FIRST(1'b1), .DWELL(3)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_data    (a_in_data),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .S          (a_S),
        .D          (a_D),
        .slot_valid (a_slot_valid),
        .busy       (a_busy),
        .done       (a_done)
    );

    demux_scan_ctrl #(.LSB_FIRST(1'b0), .DWELL(3)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_data    (b_in_data),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .S          (b_S),
        .D          (b_D),
        .slot_valid (b_slot_valid),
        .busy       (b_busy),
        .done       (b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int inst);
        return (inst == 0) ? qa.size() : qb.size();
    endfunction

    task automatic push_scan(input int inst, input logic [7:0] seq);
        slot_t e;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < DW; r++) begin
                e.s    = (inst == 0) ? 3'(k) : 3'(7 - k);
                e.d    = seq[k];
                e.last = (k == 7) && (r == DW - 1);
                if (inst == 0) qa.push_back(e);
                else           qb.push_back(e);
            end
        end
    endtask

    task automatic mon(input int inst, input logic sv, input logic [2:0] s, input logic d,
                       input logic bsy, input logic dn, input logic rdy);
        slot_t e;
        chk($sformatf("done_%0d", inst), dn, done_exp[inst]);
        done_exp[inst] = 1'b0;
        if (sv) begin
            run[inst]++;
            if (run[inst] > run_max[inst]) run_max[inst] = run[inst];
            if (qsize(inst) == 0) begin
                chk($sformatf("unexpected_slot_%0d", inst), 1, 0);
                cont[inst] = 1'b0;
            end else begin
                e = (inst == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("S_%0d", inst), s, e.s);
                chk($sformatf("D_%0d", inst), d, e.d);
                chk($sformatf("busy_%0d", inst), bsy, 1);
                chk($sformatf("in_ready_scan_%0d", inst), rdy, e.last);
                done_exp[inst] = e.last;
                cont[inst]     = !e.last;
            end
        end else begin
            run[inst] = 0;
            chk($sformatf("slot_gap_%0d", inst), cont[inst], 0);
            chk($sformatf("idle_S_D_busy_%0d", inst), {s, d, bsy}, 5'b0);
            chk($sformatf("in_ready_idle_%0d", inst), rdy, 1);
            cont[inst] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) mon(0, a_slot_valid, a_S, a_D, a_busy, a_done, a_in_ready);
        else begin
            run[0] = 0;
            done_exp[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) mon(1, b_slot_valid, b_S, b_D, b_busy, b_done, b_in_ready);
        else begin
            run[1] = 0;
            done_exp[1] = 1'b0;
        end
    end

    task automatic drive(input int inst, input logic v, input logic [7:0] dat);
        if (inst == 0) begin
            a_in_valid = v;
            a_in_data  = dat;
        end else begin
            b_in_valid = v;
            b_in_data  = dat;
        end
    endtask

    task automatic wait_idle(input int inst);
        bit ok = 1'b0;
        for (int i = 0; i < 20 * DW + 10; i++) begin
            @(posedge clk);
            if (qsize(inst) == 0 && !done_exp[inst]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("wait_idle_timeout_%0d", inst), ok, 1);
    endtask

    task automatic send_word(input int inst, input logic [7:0] dat, input logic [7:0] seq);
        @(posedge clk);
        #1;
        drive(inst, 1'b1, dat);
        push_scan(inst, seq);
        @(posedge clk);
        #1;
        drive(inst, 1'b0, ~dat);
        @(negedge clk);
        chk($sformatf("first_slot_latency_%0d", inst),
            (inst == 0) ? a_slot_valid : b_slot_valid, 1);
        wait_idle(inst);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{inst: 0, data: 8'hA5, seq: 8'hA5};
        vecs[1] = '{inst: 0, data: 8'h3C, seq: 8'h3C};
        vecs[2] = '{inst: 0, data: 8'h00, seq: 8'h00};
        vecs[3] = '{inst: 0, data: 8'h80, seq: 8'h80};
        vecs[4] = '{inst: 1, data: 8'h01, seq: 8'h80};
        vecs[5] = '{inst: 1, data: 8'hC2, seq: 8'h43};
        vecs[6] = '{inst: 1, data: 8'hFF, seq: 8'hFF};
        vecs[7] = '{inst: 1, data: 8'h80, seq: 8'h01};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_outputs", {a_S, a_D, a_slot_valid, a_busy, a_done}, 7'b0);
        chk("rst_b_outputs", {b_S, b_D, b_slot_valid, b_busy, b_done}, 7'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready_a", a_in_ready, 1);
        chk("rst_release_ready_b", b_in_ready, 1);

        // Table-driven scans
        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].inst, vecs[i].data, vecs[i].seq);
        end

        // Reset during slot 3 of a 0xFF scan
        @(posedge clk);
        #1;
        drive(0, 1'b1, 8'hFF);
        push_scan(0, 8'hFF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00);
        repeat (3 * DW) @(posedge clk);
        #1;
        chk("pre_reset_slot3", a_S, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs", {a_S, a_D, a_slot_valid, a_busy, a_done}, 7'b0);
        qa.delete();
        done_exp[0] = 1'b0;
        cont[0]     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", a_in_ready, 1);
        chk("post_reset_no_done", a_done, 0);
        wait_idle(0);

        // Back-to-back: in_valid held across both words
        run_max[0] = 0;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 8'h0F);
        push_scan(0, 8'h0F);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 8'hF0);
        push_scan(0, 8'hF0);
        repeat (8 * DW) @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00);
        wait_idle(0);
        chk("b2b_consecutive_slots", run_max[0], 16 * DW);

        // Input hold and stall: data churns and a mid-scan pulse must be ignored
        @(posedge clk);
        #1;
        drive(0, 1'b1, 8'h5A);
        push_scan(0, 8'h5A);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'hFF);
        repeat (2 * DW) @(posedge clk);
        #1;
        drive(0, 1'b1, 8'h33);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'($urandom));
        @(posedge clk);
        #1;
        a_in_data = 8'($urandom);
        wait_idle(0);

        repeat (3) @(posedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
